// File: rtl/alu_secuencial.sv
// Registered ALU: ADD/SUB/AND/OR/XOR/SHL complete in one cycle, MUL is a BITS-cycle shift-add.
// Latency: 1 cycle for single-cycle ops (done in cycle after start), BITS+1 cycles for MUL.
// Backpressure: start is sampled only while busy=0; starts during a MUL are dropped.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   A, B            unsigned operands (BITS wide), op: 3-bit opcode, start: request
//   busy            multiplier running; done: one-cycle completion pulse
//   res, res_hi     result (res_hi is MUL high half, 0 otherwise)
//   invalido, cero  overflow/illegal flag and zero flag, held with res
module alu_secuencial #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  input  logic [2:0]      op,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] res,
  output logic [BITS-1:0] res_hi,
  output logic            invalido,
  output logic            cero
);

  localparam int SHAMT = $clog2(BITS);
  localparam int CNTW  = $clog2(BITS + 1);
  // SHL is evaluated in a field wide enough for the largest encodable shift,
  // so bits shifted out are never lost even when BITS is not a power of two.
  localparam int SHW   = BITS + (1 << SHAMT);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [2*BITS-1:0]   mcand_q, mcand_d;
  logic [BITS-1:0]     mplier_q, mplier_d;
  logic [2*BITS-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [BITS-1:0]     res_q, res_d;
  logic [BITS-1:0]     res_hi_q, res_hi_d;
  logic                inv_q, inv_d;
  logic                cero_q, cero_d;

  // Single-cycle datapath
  logic [BITS:0]       add_full;
  logic [SHW-1:0]      shl_full;
  logic [BITS-1:0]     sc_res;
  logic                sc_inv;

  // One multiplier step: add the (already pre-shifted) multiplicand when the
  // current multiplier LSB is set.
  logic [2*BITS-1:0]   acc_step;

  always_comb begin
    add_full = {1'b0, A} + {1'b0, B};
    shl_full = {{(SHW-BITS){1'b0}}, A} << B[SHAMT-1:0];
    sc_res   = '0;
    sc_inv   = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = add_full[BITS-1:0];
        sc_inv = add_full[BITS];
      end
      OP_SUB: begin
        sc_res = A - B;
        sc_inv = (A < B);
      end
      OP_AND: sc_res = A & B;
      OP_OR:  sc_res = A | B;
      OP_XOR: sc_res = A ^ B;
      OP_SHL: begin
        sc_res = shl_full[BITS-1:0];
        sc_inv = |shl_full[SHW-1:BITS];
      end
      default: begin
        // Illegal opcode (MUL never takes this path): zero result, flagged.
        sc_res = '0;
        sc_inv = 1'b1;
      end
    endcase
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    inv_d    = inv_q;
    cero_d   = cero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_d  = {{BITS{1'b0}}, A};
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL_RUN;
          end else begin
            res_d    = sc_res;
            res_hi_d = '0;
            inv_d    = sc_inv;
            cero_d   = (sc_res == '0);
            done_d   = 1'b1;
          end
        end
      end

      MUL_RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNTW'(1);
        // Last iteration: publish the product straight from this step's sum.
        if (cnt_q == CNTW'(BITS - 1)) begin
          res_d    = acc_step[BITS-1:0];
          res_hi_d = acc_step[2*BITS-1:BITS];
          inv_d    = |acc_step[2*BITS-1:BITS];
          cero_d   = (acc_step == '0);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      res_q    <= '0;
      res_hi_q <= '0;
      inv_q    <= 1'b0;
      cero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      inv_q    <= inv_d;
      cero_q   <= cero_d;
    end
  end

  assign busy     = (state_q == MUL_RUN);
  assign done     = done_q;
  assign res      = res_q;
  assign res_hi   = res_hi_q;
  assign invalido = inv_q;
  assign cero     = cero_q;

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed bench for alu_secuencial (BITS=8) with hand-computed expected values.
// Inputs are driven and outputs sampled on the falling clock edge.
// Ends with one summary line and $finish.
module tb_alu_secuencial;

  localparam int BITS = 8;

  logic            clk;
  logic            reset;
  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic [2:0]      op;
  logic            start;
  logic            busy;
  logic            done;
  logic [BITS-1:0] res;
  logic [BITS-1:0] res_hi;
  logic            invalido;
  logic            cero;

  int checks;
  int errors;
  logic [BITS-1:0] last_res;

  alu_secuencial #(.BITS(BITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (a),
    .B        (b),
    .op       (op),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .res      (res),
    .res_hi   (res_hi),
    .invalido (invalido),
    .cero     (cero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Single-cycle op: start for one cycle, expect done next cycle, then a held result.
  task automatic run_single(input string tag, input logic [2:0] o, input logic [7:0] x,
                            input logic [7:0] y, input logic [7:0] er, input logic ei,
                            input logic ec);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " done"}, done, 1);
    check({tag, " busy"}, busy, 0);
    check({tag, " res"}, res, er);
    check({tag, " res_hi"}, res_hi, 0);
    check({tag, " invalido"}, invalido, ei);
    check({tag, " cero"}, cero, ec);
    @(negedge clk);
    check({tag, " done pulse"}, done, 0);
    check({tag, " res hold"}, res, er);
    last_res = er;
  endtask

  // MUL: busy in cycles 1..8, done in cycle 9. Optionally inject an ignored
  // ADD start in cycle 4, and optionally start an ADD 3+4 in the done cycle.
  task automatic run_mul(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] eh, input logic [7:0] el, input logic ei,
                         input bit inject, input bit chain);
    int dones;
    dones = 0;
    @(negedge clk);
    op = 3'b101; a = x; b = y; start = 1'b1;
    for (int c = 1; c <= BITS + 1; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done) dones++;
      if (c <= BITS) begin
        check({tag, " busy"}, busy, 1);
        check({tag, " res held"}, res, last_res);
      end
      if (inject && c == 4) begin
        start = 1'b1; op = 3'b000; a = 8'h01; b = 8'h01;
      end
      if (inject && c == 5) start = 1'b0;
      if (c == BITS + 1) begin
        check({tag, " done"}, done, 1);
        check({tag, " busy end"}, busy, 0);
        check({tag, " res_hi"}, res_hi, eh);
        check({tag, " res"}, res, el);
        check({tag, " invalido"}, invalido, ei);
        check({tag, " cero"}, cero, (eh == 8'h00 && el == 8'h00) ? 1 : 0);
        if (chain) begin
          op = 3'b000; a = 8'd3; b = 8'd4; start = 1'b1;
        end
      end
    end
    @(negedge clk);
    if (chain) begin
      start = 1'b0;
      check({tag, " chained done"}, done, 1);
      check({tag, " chained res"}, res, 8'h07);
      last_res = 8'h07;
    end else begin
      if (done) dones++;
      last_res = el;
    end
    check({tag, " done count"}, dones, 1);
  endtask

  initial begin
    int dones;
    checks = 0;
    errors = 0;
    last_res = '0;
    reset = 1'b1;
    a = '0; b = '0; op = '0; start = 1'b0;

    repeat (2) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst res", res, 0);
    check("rst res_hi", res_hi, 0);
    check("rst invalido", invalido, 0);
    check("rst cero", cero, 1);
    reset = 1'b0;

    run_single("add carry", 3'b000, 8'd200, 8'd100, 8'h2C, 1'b1, 1'b0);
    run_single("add small", 3'b000, 8'd3,   8'd4,   8'h07, 1'b0, 1'b0);
    run_single("sub borrow", 3'b001, 8'd5,  8'd7,   8'hFE, 1'b1, 1'b0);
    run_single("and zero", 3'b010, 8'hF0,  8'h0F,   8'h00, 1'b0, 1'b1);
    run_single("or", 3'b011, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0);
    run_single("xor", 3'b100, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0);
    run_single("shl out", 3'b110, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0);
    run_single("shl 3", 3'b110, 8'h01, 8'h0B, 8'h08, 1'b0, 1'b0);
    run_single("shl 0", 3'b110, 8'h5A, 8'h08, 8'h5A, 1'b0, 1'b0);
    run_single("illegal", 3'b111, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1);

    // Back-to-back starts on consecutive cycles
    @(negedge clk);
    op = 3'b000; a = 8'd3; b = 8'd4; start = 1'b1;
    @(negedge clk);
    check("b2b first done", done, 1);
    check("b2b first res", res, 8'h07);
    op = 3'b100; a = 8'hAA; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    check("b2b second done", done, 1);
    check("b2b second res", res, 8'h55);
    @(negedge clk);
    check("b2b quiet", done, 0);
    last_res = 8'h55;

    run_mul("mul 200x3",   8'd200, 8'd3,   8'h02, 8'h58, 1'b1, 1'b0, 1'b0);
    run_mul("mul 15x17",   8'd15,  8'd17,  8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_mul("mul max",     8'hFF,  8'hFF,  8'hFE, 8'h01, 1'b1, 1'b0, 1'b0);
    run_mul("mul zero",    8'h00,  8'h00,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run_mul("mul ignore",  8'd200, 8'd3,   8'h02, 8'h58, 1'b1, 1'b1, 1'b0);
    run_mul("mul chain",   8'd15,  8'd17,  8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in cycle 5 of a MUL aborts it without a done.
    @(negedge clk);
    op = 3'b101; a = 8'd200; b = 8'd3; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    check("arst busy", busy, 0);
    check("arst done", done, 0);
    check("arst res", res, 0);
    check("arst res_hi", res_hi, 0);
    check("arst invalido", invalido, 0);
    check("arst cero", cero, 1);
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("arst no done", dones, 0);
    check("arst idle", busy, 0);
    last_res = '0;
    run_single("add after rst", 3'b000, 8'd200, 8'd100, 8'h2C, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_secuencial.md
Name: alu_secuencial

Overview:
- Parametrised, registered ALU that generalises the team's combinational 4-op ALU.
- Adds XOR, logical shift-left and a multi-cycle unsigned shift-add multiplier.
- Uses a start/busy/done handshake, a registered result held until the next completion, and zero and invalid flags.
- Sits between the operand/opcode registers driven by switches or the control FSM and the display/result logic.

Parameters:
- BITS, 8, operand and result width. Legal values are 4 to 32. SHAMT = $clog2(BITS) is derived, not user-set.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- A  in  BITS  operand A, unsigned.
- B  in  BITS  operand B, unsigned.
- op  in  3  opcode, sampled with start.
- start  in  1  request. Sampled only when busy=0.
- busy  out  1  a multi-cycle operation is in progress.
- done  out  1  one-cycle pulse; res, res_hi and flags are valid and updated.
- res  out  BITS  result, low half for MUL.
- res_hi  out  BITS  MUL high half. 0 for all other ops.
- invalido  out  1  result does not fit or opcode illegal. Holds with res.
- cero  out  1  res==0 and res_hi==0. Holds with res.

Behaviour:
- Reset, asynchronous: state=IDLE, busy=0, done=0, res=0, res_hi=0, invalido=0, cero=1. The multiplier accumulator and counter are cleared. Reset mid-MUL aborts it and gives no done.
- Opcodes, with BITS-wide arithmetic and an extra carry bit:
  - 000 ADD: res=A+B. invalido = carry out.
  - 001 SUB: res=A-B modulo 2^BITS. invalido = borrow (A<B).
  - 010 AND: invalido=0.
  - 011 OR: invalido=0.
  - 100 XOR: invalido=0.
  - 101 MUL: {res_hi,res}=A*B. invalido = (res_hi!=0).
  - 110 SHL: res = A << B[SHAMT-1:0]. invalido=1 if any 1 bit is shifted out. B upper bits are ignored.
  - 111: illegal. res=0, res_hi=0, invalido=1, cero=1.
- States:
  - IDLE: the only state that samples start.
  - MUL_RUN: BITS iterations.
- Single-cycle ops (all except 101):
  - With start=1 in IDLE at edge E0, outputs are registered at E0 and done=1 in the next cycle (latency 1).
  - busy stays 0. Back-to-back starts on consecutive cycles each produce a done pulse in the following cycle.
- MUL:
  - At E0, latch A and B into a multiplicand/multiplier register, clear the 2*BITS accumulator and counter, and go to MUL_RUN. busy=1 from the cycle after E0.
  - Each edge E1..E_BITS: if the multiplier LSB is 1, add the multiplicand (shifted by the count) into the accumulator; shift the multiplier right; increment the counter.
  - At E_BITS: write res, res_hi, invalido and cero; done=1 and busy=0 in cycle BITS+1; return to IDLE.
- Handshake edge cases:
  - start while busy=1 is ignored; A, B and op changes are ignored too.
  - start in the same cycle as done, when busy=0, is accepted.
- done:
  - Exactly one cycle per accepted start.
  - Not asserted for ignored starts.
- Outputs res, res_hi, invalido and cero change only on a done-producing edge or on reset. They hold otherwise, including while MUL is running.
- Boundaries:
  - A=B=0 MUL gives res=0, cero=1, invalido=0.
  - MUL of max*max, for BITS=8 255*255=0xFE01: res_hi=0xFE, res=0x01, invalido=1.
  - SHL by 0 gives res=A, invalido=0.

Test Plan (BITS=8):
- ADD A=200, B=100, start 1 cycle -> next cycle done=1, res=0x2C, invalido=1, cero=0. ADD 3+4 -> res=7, invalido=0.
- SUB A=5, B=7 -> res=0xFE, invalido=1. AND 0xF0,0x0F -> res=0, cero=1, invalido=0. XOR 0xAA,0xFF -> res=0x55.
- MUL A=200, B=3 -> busy=1 for cycles 1..8; done=1 in cycle 9 with res_hi=0x02, res=0x58, invalido=1. MUL 15*17 -> res=0xFF, res_hi=0, invalido=0.
- During MUL, pulse start with ADD at cycle 4 -> ignored: exactly one done, MUL result intact, res unchanged until cycle 9.
- SHL A=0x81, B=1 -> res=0x02, invalido=1. SHL A=0x01, B=0x0B (shift 3) -> res=0x08, invalido=0. op=111 -> res=0, invalido=1, cero=1.
- Assert reset asynchronously (between clock edges) at cycle 5 of a MUL -> all outputs go to reset values immediately, no done follows. A new ADD after release completes normally.
